pixel_edge_pipeline: RTL and testbench
======================================

# pixel_edge_pipeline

Parametrised, handshaked successor to the fixed five-pixel edge-detector pipeline. Each beat carries `LANES` multi-channel pixels. The block computes a per-pixel luma sum and flags an edge wherever adjacent pixels differ by more than a runtime threshold, including across beat boundaries. An optional temporal-smoothing stage averages each pixel with the same lane of the previous beat. It sits between the pixel source and the edge consumer in the video path.

## Interface
- `PIXEL_W`, 24, bits per pixel; must be divisible by `CHANNELS`.
- `CHANNELS`, 3, colour channels per pixel; `CHAN_W = PIXEL_W/CHANNELS`.
- `LANES`, 5, pixels per beat, ≥2; lane 0 is leftmost.
- Derived: `LUMA_W = CHAN_W + $clog2(CHANNELS)`.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: input beat present.
- `in_ready` out 1: input beat accepted when high with `in_valid`.
- `in_sof` in 1: first beat of a line/frame; clears history; qualified by `in_valid`.
- `in_pixels` in `LANES*PIXEL_W`: lane i at bits `[i*PIXEL_W +: PIXEL_W]`.
- `threshold` in `LUMA_W`: sampled with the beat and carried along the pipeline.
- `out_valid` out 1: output beat present.
- `out_ready` in 1: consumer accepts.
- `out_pixels` out `LANES*PIXEL_W`: pixels as used for detection (smoothed if enabled).
- `out_edges` out `LANES`: bit i is the edge between lane i and its left neighbour.

## Operation
**Pipeline stages** (each holds a valid bit plus payload):
- **S1 capture:** registers pixels, `sof`, `threshold`.
- **S2 smooth** (only with macro): per channel, out = `(cur + prev) >> 1`, floor. `prev` is the same lane of the previous beat leaving S1. On `sof`, or on the first beat after reset, `prev` := `cur`, so the pixel passes through.
- **S3 luma:** `luma[i]` = unsigned sum of the pixel's `CHANNELS` channel fields, `LUMA_W` bits, no overflow.
- **S4 diff:** `d[i] = |luma[i] - luma[i-1]|` for i≥1. `d[0] = |luma[0] - last_luma|`, where `last_luma` is lane `LANES-1` luma of the previous beat through S4. `d[0]` is forced 0 on `sof` or the first beat after reset.
- **S5 compare:** `edge[i] = d[i] > threshold` (strict), with the threshold from this beat. Drives `out_*` registers.

**History rules:**
- History registers (`prev` pixels, `last_luma`, `hist_valid`) update only when a beat advances out of the owning stage.
- Stalls never corrupt history.

**Flow control:**
- Stage k loads when it is empty or its content advances: `adv_k = valid_k & (next stage loads)`. The last stage advances on `out_ready`.
- `in_ready` = S1 loads; combinational from `out_ready` through the chain, with no skid buffer.
- Bubbles collapse: an empty stage accepts regardless of downstream.
- Throughput is one beat per cycle when `out_ready` is held high.
- Payload is held stable while `out_valid & ~out_ready`.

**Reset (async):**
- All valid bits, `out_valid`, `out_edges`, `out_pixels`, `hist_valid`, `prev`, `last_luma`, and stored thresholds clear to 0.
- `in_ready` is 1 once reset deasserts, since the pipeline is empty.
- Reset mid-operation discards all in-flight beats; no partial output appears.

## Timing
- **Latency**, beat accepted at edge N, no stalls:
  - 4 cycles without the macro: `out_valid` high after edge N+3, available at edge N+4 sample.
  - 5 cycles with the macro.
- **Back-pressure:** `out_ready` low for M cycles adds exactly M cycles to in-flight beats. Beats are never dropped or duplicated.
- **Simultaneous `in_sof` and stall:** `sof` travels with its beat. History clears when that beat passes the owning stage, not when `in_sof` is presented.
- **Threshold changes** affect only beats accepted after the change.

## Configuration
- **`PIXEL_EDGE_SMOOTH_EN` defined:**
  - S2 is present; latency is 5.
  - `out_pixels` carries the smoothed values, and edges are computed on them.
- **Undefined:**
  - S2 is removed entirely (no registers, no `prev` storage); latency is 4.
  - `out_pixels` equals the input pixels.

## Test plan
Default parameters (24-bit pixels, 3×8-bit channels, 5 lanes):
- **Gradient beat:** `in_sof=1`, lanes with all channels = 0, 10, 40, 40, 100, `threshold=60`.
  - Lumas are 0, 30, 120, 120, 300; diffs are 0, 30, 90, 0, 180.
  - Expected `out_edges=5'b10100`, appearing 4 cycles later (5 with the macro).
- **Boundary edge:** next beat without `sof`, all lanes 0, `threshold=60`.
  - `d[0] = 300`, expected `out_edges=5'b00001`.
  - Repeat with `in_sof=1` → `5'b00000`.
- **Back-pressure:** stream 8 distinct beats with `out_ready` toggling 1,0,0,1,…
  - All 8 emerge in order, unchanged while stalled.
  - `in_ready` drops only when all stages are full.
- **Reset mid-stream:** pulse `reset` for 1 cycle with 3 beats in flight.
  - `out_valid=0` immediately (async).
  - The next accepted beat is treated as first (`d[0]=0`).
- **Smoothing** (macro on): beat A lane 0 = 0x102030, then beat B lane 0 = 0x304050.
  - B's `out_pixels` lane 0 = 0x203040.
  - A passes through unchanged as the first beat.
- **Threshold equality:** `d = threshold = 45` → edge 0; `d = 46` → edge 1.

Source files
------------

// File: rtl/pixel_edge_pipeline.sv
// Handshaked multi-lane edge detector: capture, optional temporal smoothing, luma, diff, compare.
// Define PIXEL_EDGE_SMOOTH_EN to include the temporal-smoothing stage (adds one cycle of latency).
module pixel_edge_pipeline #(
  parameter int  PIXEL_W  = 24,
  parameter int  CHANNELS = 3,
  parameter int  LANES    = 5,
  localparam int CHAN_W   = PIXEL_W / CHANNELS,
  localparam int LUMA_W   = CHAN_W + $clog2(CHANNELS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sof,
  input  logic [LANES*PIXEL_W-1:0] in_pixels,
  input  logic [LUMA_W-1:0]        threshold,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*PIXEL_W-1:0] out_pixels,
  output logic [LANES-1:0]         out_edges
);

  localparam int PW = LANES * PIXEL_W;
  localparam int LW = LANES * LUMA_W;

  function automatic logic [LUMA_W-1:0] luma_f(input logic [PIXEL_W-1:0] pix);
    logic [LUMA_W-1:0] acc;
    acc = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      acc = acc + LUMA_W'(pix[c*CHAN_W +: CHAN_W]);
    end
    return acc;
  endfunction

  function automatic logic [LUMA_W-1:0] absdiff_f(input logic [LUMA_W-1:0] a, input logic [LUMA_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic              s1_valid_r, s1_sof_r;
  logic [PW-1:0]     s1_pix_r;
  logic [LUMA_W-1:0] s1_thr_r;

  logic              pre_valid_s, pre_sof_s;
  logic [PW-1:0]     pre_pix_s;
  logic [LUMA_W-1:0] pre_thr_s;

  logic              s3_valid_r, s3_sof_r;
  logic [PW-1:0]     s3_pix_r;
  logic [LUMA_W-1:0] s3_thr_r;
  logic [LW-1:0]     s3_luma_r;

  logic              s4_valid_r;
  logic [PW-1:0]     s4_pix_r;
  logic [LUMA_W-1:0] s4_thr_r;
  logic [LW-1:0]     s4_diff_r;
  logic [LUMA_W-1:0] last_luma_r;
  logic              luma_hist_r;

  logic              ld_s1_s, ld_s3_s, ld_s4_s, ld_out_s;
  logic [LW-1:0]     luma_s;
  logic [LW-1:0]     diff_s;
  logic [LANES-1:0]  edge_s;

  // A stage loads when empty or when its beat moves on; the chain ends at out_ready.
  assign ld_out_s = ~out_valid | out_ready;
  assign ld_s4_s  = ~s4_valid_r | ld_out_s;
  assign ld_s3_s  = ~s3_valid_r | ld_s4_s;
  assign in_ready = ld_s1_s;

`ifdef PIXEL_EDGE_SMOOTH_EN
  logic              s2_valid_r, s2_sof_r;
  logic [PW-1:0]     s2_pix_r;
  logic [LUMA_W-1:0] s2_thr_r;
  logic [PW-1:0]     prev_pix_r;
  logic              prev_hist_r;
  logic              ld_s2_s;
  logic [PW-1:0]     smooth_s;

  function automatic logic [CHAN_W-1:0] avg_f(input logic [CHAN_W-1:0] a, input logic [CHAN_W-1:0] b);
    logic [CHAN_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CHAN_W:1];
  endfunction

  assign ld_s2_s     = ~s2_valid_r | ld_s3_s;
  assign ld_s1_s     = ~s1_valid_r | ld_s2_s;
  assign pre_valid_s = s2_valid_r;
  assign pre_sof_s   = s2_sof_r;
  assign pre_pix_s   = s2_pix_r;
  assign pre_thr_s   = s2_thr_r;

  // Floor average with the same lane of the previous beat; first beat of a line passes through.
  always_comb begin
    smooth_s = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int c = 0; c < CHANNELS; c++) begin
        smooth_s[i*PIXEL_W + c*CHAN_W +: CHAN_W] =
          avg_f(s1_pix_r[i*PIXEL_W + c*CHAN_W +: CHAN_W],
                (s1_sof_r | ~prev_hist_r) ? s1_pix_r[i*PIXEL_W + c*CHAN_W +: CHAN_W]
                                          : prev_pix_r[i*PIXEL_W + c*CHAN_W +: CHAN_W]);
      end
    end
  end

  // Smoothing stage register and its raw-pixel history.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid_r  <= 1'b0;
      s2_sof_r    <= 1'b0;
      s2_pix_r    <= '0;
      s2_thr_r    <= '0;
      prev_pix_r  <= '0;
      prev_hist_r <= 1'b0;
    end else if (ld_s2_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_sof_r    <= s1_sof_r;
        s2_pix_r    <= smooth_s;
        s2_thr_r    <= s1_thr_r;
        prev_pix_r  <= s1_pix_r;
        prev_hist_r <= 1'b1;
      end
    end
  end
`else
  assign ld_s1_s     = ~s1_valid_r | ld_s3_s;
  assign pre_valid_s = s1_valid_r;
  assign pre_sof_s   = s1_sof_r;
  assign pre_pix_s   = s1_pix_r;
  assign pre_thr_s   = s1_thr_r;
`endif

  // Capture stage register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_sof_r   <= 1'b0;
      s1_pix_r   <= '0;
      s1_thr_r   <= '0;
    end else if (ld_s1_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_sof_r <= in_sof;
        s1_pix_r <= in_pixels;
        s1_thr_r <= threshold;
      end
    end
  end

  // Per-lane channel sums.
  always_comb begin
    luma_s = '0;
    for (int i = 0; i < LANES; i++) begin
      luma_s[i*LUMA_W +: LUMA_W] = luma_f(pre_pix_s[i*PIXEL_W +: PIXEL_W]);
    end
  end

  // Luma stage register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s3_valid_r <= 1'b0;
      s3_sof_r   <= 1'b0;
      s3_pix_r   <= '0;
      s3_thr_r   <= '0;
      s3_luma_r  <= '0;
    end else if (ld_s3_s) begin
      s3_valid_r <= pre_valid_s;
      if (pre_valid_s) begin
        s3_sof_r  <= pre_sof_s;
        s3_pix_r  <= pre_pix_s;
        s3_thr_r  <= pre_thr_s;
        s3_luma_r <= luma_s;
      end
    end
  end

  // Neighbour differences; lane 0 compares against the rightmost lane of the previous beat.
  always_comb begin
    diff_s = '0;
    for (int i = 1; i < LANES; i++) begin
      diff_s[i*LUMA_W +: LUMA_W] = absdiff_f(s3_luma_r[i*LUMA_W +: LUMA_W], s3_luma_r[(i-1)*LUMA_W +: LUMA_W]);
    end
    if (s3_sof_r | ~luma_hist_r) begin
      diff_s[0 +: LUMA_W] = '0;
    end else begin
      diff_s[0 +: LUMA_W] = absdiff_f(s3_luma_r[0 +: LUMA_W], last_luma_r);
    end
  end

  // Diff stage register and cross-beat luma history.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s4_valid_r  <= 1'b0;
      s4_pix_r    <= '0;
      s4_thr_r    <= '0;
      s4_diff_r   <= '0;
      last_luma_r <= '0;
      luma_hist_r <= 1'b0;
    end else if (ld_s4_s) begin
      s4_valid_r <= s3_valid_r;
      if (s3_valid_r) begin
        s4_pix_r    <= s3_pix_r;
        s4_thr_r    <= s3_thr_r;
        s4_diff_r   <= diff_s;
        last_luma_r <= s3_luma_r[(LANES-1)*LUMA_W +: LUMA_W];
        luma_hist_r <= 1'b1;
      end
    end
  end

  // Strict threshold compare.
  always_comb begin
    edge_s = '0;
    for (int i = 0; i < LANES; i++) begin
      edge_s[i] = (s4_diff_r[i*LUMA_W +: LUMA_W] > s4_thr_r) ? 1'b1 : 1'b0;
    end
  end

  // Output register; payload holds while the consumer stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_pixels <= '0;
      out_edges  <= '0;
    end else if (ld_out_s) begin
      out_valid <= s4_valid_r;
      if (s4_valid_r) begin
        out_pixels <= s4_pix_r;
        out_edges  <= edge_s;
      end
    end
  end

endmodule

// File: tb/tb_pixel_edge_pipeline.sv
// Scoreboard bench for pixel_edge_pipeline: directed beats with hand-computed edges, decoupled monitor.
module tb_pixel_edge_pipeline;

`ifdef PIXEL_EDGE_SMOOTH_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  typedef struct {
    logic [119:0] pix;
    logic [4:0]   edg;
    bit           chk_lat;
    int           cyc;
  } exp_t;

  logic         clock, reset, in_valid, in_ready, in_sof, out_valid, out_ready;
  logic [119:0] in_pixels, out_pixels;
  logic [9:0]   threshold;
  logic [4:0]   out_edges;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  pixel_edge_pipeline dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_pixels(in_pixels), .threshold(threshold), .out_valid(out_valid), .out_ready(out_ready),
    .out_pixels(out_pixels), .out_edges(out_edges)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever @(posedge clock) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [119:0] beat5(input logic [23:0] p0, input logic [23:0] p1,
                                         input logic [23:0] p2, input logic [23:0] p3,
                                         input logic [23:0] p4);
    return {p4, p3, p2, p1, p0};
  endfunction

  // Called at posedge+2; returns at posedge+2 after the beat is accepted.
  task automatic send(input logic [119:0] pix, input logic sof, input logic [9:0] thr,
                      input logic [4:0] edg, input logic [119:0] exp_pix, input bit lat);
    exp_t e;
    bit   ok;
    ok        = 1'b0;
    in_valid  = 1'b1;
    in_sof    = sof;
    in_pixels = pix;
    threshold = thr;
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      if (in_ready) begin
        e.pix = exp_pix; e.edg = edg; e.chk_lat = lat; e.cyc = cyc;
        sb_q.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    check("send_accept", {127'd0, ok}, 128'd1);
    @(posedge clock);
    #2;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sb_q.size() != 0; t++) @(negedge clock);
    check("drain_empty", 128'(sb_q.size()), 128'd0);
    @(posedge clock);
    #2;
  endtask

  // Monitor: pops expected beats on each output handshake; also checks stall hold and in_ready.
  initial begin
    exp_t         e;
    bit           stall_r;
    int           inflight;
    logic [119:0] held_pix;
    logic [4:0]   held_edg;
    stall_r  = 1'b0;
    inflight = 0;
    held_pix = '0;
    held_edg = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        stall_r  = 1'b0;
        inflight = 0;
      end else begin
        check("in_ready", {127'd0, in_ready}, {127'd0, !(inflight == LAT && !out_ready)});
        if (stall_r) begin
          check("stall_hold", {2'd0, out_valid, out_edges, out_pixels}, {2'd0, 1'b1, held_edg, held_pix});
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check("unexpected_output", 128'd1, 128'd0);
          end else begin
            e = sb_q.pop_front();
            check("out_edges", {123'd0, out_edges}, {123'd0, e.edg});
            check("out_pixels", {8'd0, out_pixels}, {8'd0, e.pix});
            if (e.chk_lat) check("latency", 128'(cyc - e.cyc), 128'(LAT));
          end
        end
        stall_r  = out_valid && !out_ready;
        held_pix = out_pixels;
        held_edg = out_edges;
        inflight = inflight + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      end
    end
  end

  initial begin
    logic [119:0] g_px, z_px, t_px, px;
    logic [7:0]   bpv [8];
    logic [4:0]   bpe [8];
    bpv = '{8'd10, 8'd40, 8'd41, 8'd0, 8'd100, 8'd80, 8'd81, 8'd200};
    bpe = '{5'b00000, 5'b00001, 5'b00000, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 5'b00001};
    g_px = beat5(24'h000000, 24'h0A0A0A, 24'h282828, 24'h282828, 24'h646464);
    z_px = 120'd0;
    t_px = beat5(24'h000000, 24'h0F0F0F, 24'h1E1E1F, 24'h1E1E1F, 24'h2E2E2D);

    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixels = '0; threshold = '0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_out_valid", {127'd0, out_valid}, 128'd0);
    check("reset_out_edges", {123'd0, out_edges}, 128'd0);
    check("reset_out_pixels", {8'd0, out_pixels}, 128'd0);
    #1;
    reset = 1'b0;
    #1;
    check("ready_after_reset", {127'd0, in_ready}, 128'd1);
    @(posedge clock);
    #2;

    // Gradient: lumas 0,30,120,120,300 -> diffs 0,30,90,0,180 over 60.
    send(g_px, 1'b1, 10'd60, 5'b10100, g_px, 1'b1);
`ifdef PIXEL_EDGE_SMOOTH_EN
    send(z_px, 1'b0, 10'd60, 5'b10001, beat5(24'h000000, 24'h050505, 24'h141414, 24'h141414, 24'h323232), 1'b0);
`else
    send(z_px, 1'b0, 10'd60, 5'b00001, z_px, 1'b0);
`endif
    send(z_px, 1'b1, 10'd60, 5'b00000, z_px, 1'b0);
    // Lumas 0,45,91,91,137 -> diffs 0,45,46,0,46 against 45.
    send(t_px, 1'b1, 10'd45, 5'b10100, t_px, 1'b0);
    drain();

`ifndef PIXEL_EDGE_SMOOTH_EN
    // Uniform beats: lumas 30,120,123,0,300,240,243,600 -> lane-0 diffs 0,90,3,123,300,60,3,357.
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          px = {15{bpv[k]}};
          send(px, (k == 0) ? 1'b1 : 1'b0, 10'd60, bpe[k], px, 1'b0);
        end
      end
      begin
        for (int k = 0; k < 60; k++) begin
          out_ready = (k % 3 == 0) ? 1'b1 : 1'b0;
          @(posedge clock);
          #2;
        end
        out_ready = 1'b1;
      end
    join
    drain();
`endif

    // Reset with three beats stalled in flight.
    out_ready = 1'b0;
    send(g_px, 1'b1, 10'd60, 5'b10100, g_px, 1'b0);
    send(t_px, 1'b0, 10'd60, 5'b00000, t_px, 1'b0);
    send(z_px, 1'b0, 10'd60, 5'b00000, z_px, 1'b0);
    repeat (2) @(posedge clock);
    #2;
    check("stalled_out_valid", {127'd0, out_valid}, 128'd1);
    reset = 1'b1;
    #1;
    check("async_reset_out_valid", {127'd0, out_valid}, 128'd0);
    sb_q.delete();
    @(posedge clock);
    #2;
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("ready_after_midreset", {127'd0, in_ready}, 128'd1);
    send(g_px, 1'b0, 10'd60, 5'b10100, g_px, 1'b1);
    drain();

`ifdef PIXEL_EDGE_SMOOTH_EN
    // A lane-0 luma 96 -> edge at lane 1; B smooths to 0x203040 (luma 144) -> lanes 0 and 1.
    send({96'd0, 24'h102030}, 1'b1, 10'd60, 5'b00010, {96'd0, 24'h102030}, 1'b1);
    send({96'd0, 24'h304050}, 1'b0, 10'd60, 5'b00011, {96'd0, 24'h203040}, 1'b0);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
